// File: rtl/spike_rate_encoder_if.sv
// Sample/spike handshake bundle between the pixel source and spike_rate_encoder.
// Master side presents samples; slave side (the encoder) returns the spike train.
interface spike_rate_encoder_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pixel;
    logic              spike;
    logic              spike_valid;
    logic              done;

    modport master (
        output in_valid, in_pixel,
        input  in_ready, spike, spike_valid, done
    );

    modport slave (
        input  in_valid, in_pixel,
        output in_ready, spike, spike_valid, done
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns one intensity sample into NUM_STEPS spike decisions.
// Define RATE_ENC_LFSR_EN for stochastic (LFSR) encoding instead of the accumulator.
module spike_rate_encoder #(
    parameter int          DATA_W    = 8,
    parameter int          NUM_STEPS = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    spike_rate_encoder_if.slave   bus
);
    localparam int STEP_W = $clog2(NUM_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic {
        IDLE,
        ENCODE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              spike_q, spike_d;
    logic              spike_valid_q, spike_valid_d;
    logic              done_q, done_d;

`ifdef RATE_ENC_LFSR_EN
    logic [15:0]       lfsr_q, lfsr_d;
    logic [DATA_W-1:0] rnd;
    assign rnd = lfsr_q[15 -: DATA_W];
`else
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W:0]   sum;
    assign sum = {1'b0, acc_q} + {1'b0, pix_q};
`endif

    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        step_d        = step_q;
        spike_d       = 1'b0;
        spike_valid_d = 1'b0;
        done_d        = 1'b0;
`ifdef RATE_ENC_LFSR_EN
        lfsr_d        = lfsr_q;
`else
        acc_d         = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ENCODE;
                    pix_d   = bus.in_pixel;
                    step_d  = '0;
`ifndef RATE_ENC_LFSR_EN
                    acc_d   = '0;
`endif
                end
            end
            ENCODE: begin
`ifdef RATE_ENC_LFSR_EN
                // All-ones forced high so full intensity always yields NUM_STEPS spikes.
                spike_d = (pix_q > rnd) || (pix_q == '1);
                lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`else
                // Carry out of the phase accumulator gives evenly spread spikes.
                spike_d = sum[DATA_W];
                acc_d   = sum[DATA_W-1:0];
`endif
                spike_valid_d = 1'b1;
                step_d        = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pix_q         <= '0;
            step_q        <= '0;
            spike_q       <= 1'b0;
            spike_valid_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef RATE_ENC_LFSR_EN
            lfsr_q        <= LFSR_SEED;
`else
            acc_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            step_q        <= step_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            done_q        <= done_d;
`ifdef RATE_ENC_LFSR_EN
            lfsr_q        <= lfsr_d;
`else
            acc_q         <= acc_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.spike       = spike_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder with hand-computed spike masks.
module tb_spike_rate_encoder;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef RATE_ENC_LFSR_EN
    localparam bit LFSR = 1'b1;
`else
    localparam bit LFSR = 1'b0;
`endif

    spike_rate_encoder_if #(.DATA_W(8)) bus ();

    spike_rate_encoder #(
        .DATA_W   (8),
        .NUM_STEPS(16),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one sample. If pre is set the sample was already presented in the previous
    // done cycle. If chain is set, next_pix is presented during this sample's done cycle.
    task automatic encode(input logic [7:0] pix, input logic [15:0] mask, input bit chk_spk,
                          input bit pre, input bit chain, input logic [7:0] next_pix,
                          output int count);
        count = 0;
        if (!pre) begin
            check("ready_before_accept", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_pixel = pix;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("gap_spike_valid", 32'(bus.spike_valid), 32'd0);
        check("gap_in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("valid_p%0d_s%0d", pix, k), 32'(bus.spike_valid), 32'd1);
            check($sformatf("done_p%0d_s%0d", pix, k), 32'(bus.done), 32'(k == 15));
            if (chk_spk)
                check($sformatf("spike_p%0d_s%0d", pix, k), 32'(bus.spike), 32'(mask[k]));
            if (bus.spike === 1'b1) count++;
            if (k < 15) begin
                bus.in_pixel = 8'($urandom);
                bus.in_valid = 1'($urandom);
            end else begin
                check("ready_in_done_cycle", 32'(bus.in_ready), 32'd1);
                bus.in_valid = chain;
                bus.in_pixel = chain ? next_pix : 8'h00;
            end
        end
        if (chk_spk)
            check($sformatf("count_p%0d", pix), 32'(count), 32'($countones(mask)));
    endtask

    initial begin
        int cnt;
        int membrane;
        bit any;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_spike", 32'(bus.spike), 32'd0);
        check("reset_spike_valid", 32'(bus.spike_valid), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        encode(8'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, cnt);
        check("p0_zero_spikes", 32'(cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_single_pulse", 32'(bus.done), 32'd0);

        encode(8'd64, 16'h8888, !LFSR, 1'b0, 1'b0, 8'd0, cnt);
        membrane = 0;
        for (int i = 0; i < cnt; i++) membrane++;
        if (!LFSR) check("if_neuron_thr5_no_fire", 32'(membrane >= 5), 32'd0);

        encode(8'd255, LFSR ? 16'hFFFF : 16'hFFFE, 1'b1, 1'b0, 1'b0, 8'd0, cnt);

        // Back-to-back: 128 then 64 presented during the done cycle.
        encode(8'd128, 16'hAAAA, !LFSR, 1'b0, 1'b1, 8'd64, cnt);
        encode(8'd64, 16'h8888, !LFSR, 1'b1, 1'b0, 8'd0, cnt);

        // Reset at step 5 of pixel 200.
        check("ready_before_200", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'd200;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("p200_valid_at_step5", 32'(bus.spike_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_spike", 32'(bus.spike), 32'd0);
        check("abort_spike_valid", 32'(bus.spike_valid), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        any = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.spike_valid !== 1'b0) any = 1'b1;
        end
        check("abort_no_late_done", 32'(any), 32'd0);

        encode(8'd64, 16'h8888, !LFSR, 1'b0, 1'b0, 8'd0, cnt);
        encode(8'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

- Upstream front-end of the spiking datapath: converts one unsigned intensity sample into a spike train of NUM_STEPS timesteps.
- Drives the single-bit `spike` input of the integrate-and-fire neuron stage, one spike decision per clock.
- Accepts samples over a valid/ready handshake, encodes them by rate (spike density proportional to intensity), and pulses `done` when a sample's train is complete.

## Interface
- DATA_W, 8, intensity width in bits.
- NUM_STEPS, 16, timesteps per sample (must be at least 1).
- LFSR_SEED, 16'hACE1, LFSR load value (non-zero); used only when RATE_ENC_LFSR_EN is defined.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  `in_pixel` is valid.
- in_ready  output  1  encoder can accept a sample; high only in IDLE.
- in_pixel  input  DATA_W  unsigned intensity.
- spike  output  1  registered spike for the current timestep; drives the neuron `spike` input.
- spike_valid  output  1  registered; high for exactly NUM_STEPS cycles per sample.
- done  output  1  registered one-cycle pulse coinciding with the last spike_valid cycle.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ENCODE: in_ready=0.
- IDLE -> ENCODE on `in_valid && in_ready`:
  - latch `in_pixel` into pix;
  - clear accumulator acc (DATA_W bits) to 0;
  - clear step counter to 0 (width $clog2(NUM_STEPS+1)).
- Each ENCODE edge:
  - sum = {1'b0,acc} + {1'b0,pix} (DATA_W+1 bits);
  - spike <= sum[DATA_W];
  - acc <= sum[DATA_W-1:0];
  - spike_valid <= 1;
  - step <= step+1.
- On the edge that issues step NUM_STEPS-1: done <= 1, state -> IDLE.
- Spike count per sample = floor(NUM_STEPS*pix / 2^DATA_W). Spikes are evenly spread; there is no rounding offset.
- Changes on `in_pixel` or `in_valid` during ENCODE are ignored.
- Outside ENCODE edges: spike, spike_valid and done register 0.
- Reset at any time, including mid-sample:
  - state=IDLE; acc, pix and step cleared;
  - spike=0, spike_valid=0, done=0, in_ready=1 from the cycle after the reset edge;
  - no `done` is issued for the aborted sample.

## Timing
- Acceptance edge t0. Edges t0+1 through t0+NUM_STEPS register steps 0 through NUM_STEPS-1.
- Step k is visible on `spike` in the cycle after edge t0+1+k.
- First spike_valid cycle begins after edge t0+1: two cycles of latency from acceptance to the first visible timestep.
- `done`=1 during the last spike_valid cycle. `in_ready` returns to 1 in that same cycle.
- Back-to-back: a sample presented while done=1 is accepted on that edge. Its step 0 follows after exactly one cycle with spike_valid=0.
- Throughput: one sample per NUM_STEPS+1 cycles.

## Configuration
- RATE_ENC_LFSR_EN undefined (default): deterministic accumulator encoding as described in Operation.
- RATE_ENC_LFSR_EN defined: stochastic (Poisson-like) encoding.
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, loaded with LFSR_SEED on reset only (not per sample).
  - LFSR advances once per ENCODE edge.
  - spike <= (pix > lfsr[15 -: DATA_W]) || (pix == all-ones).
  - Guarantees: pix=0 gives 0 spikes; pix=all-ones gives NUM_STEPS spikes.
  - Accumulator is not instantiated.
  - Handshake, timing and reset behaviour are identical to the default build.

## Test plan
- Default build unless stated.
- Reset for 2 cycles, then idle -> spike=0, spike_valid=0, done=0, in_ready=1.
- in_pixel=0 accepted -> 16 spike_valid cycles, 0 spikes, exactly one done pulse on the 16th cycle.
- in_pixel=64 -> spikes at steps 3, 7, 11, 15 only (4 total); a downstream IF neuron with threshold 5 does not fire.
- in_pixel=255 -> spikes at steps 1 through 15 (15 total); step 0 has no spike.
- in_valid held with 128, then 64 presented during the done cycle -> second sample accepted on that edge with one idle cycle in between; spike counts 8 then 4; in_pixel toggling mid-encode has no effect.
- Reset asserted at step 5 of pixel=200 -> next cycle all outputs 0 and in_ready=1, no done pulse. RATE_ENC_LFSR_EN build: pixel=255 gives 16 spikes, pixel=0 gives 0 spikes.
